// File: rtl/ahb_arbiter2.sv
// Two-master AHB-Lite arbiter with round-robin grant, per-master pending capture
// and a shared single-slave address/data phase.
module ahb_arbiter2 (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic [31:0] m0_haddr_i,
    input  logic        m0_hwrite_i,
    input  logic [2:0]  m0_hsize_i,
    input  logic [1:0]  m0_htrans_i,
    input  logic [31:0] m0_hwdata_i,
    output logic [31:0] m0_hrdata_o,
    output logic        m0_hready_o,
    output logic        m0_hresp_o,
    input  logic [31:0] m1_haddr_i,
    input  logic        m1_hwrite_i,
    input  logic [2:0]  m1_hsize_i,
    input  logic [1:0]  m1_htrans_i,
    input  logic [31:0] m1_hwdata_i,
    output logic [31:0] m1_hrdata_o,
    output logic        m1_hready_o,
    output logic        m1_hresp_o,
    output logic [31:0] s_haddr_o,
    output logic        s_hwrite_o,
    output logic [2:0]  s_hsize_o,
    output logic [1:0]  s_htrans_o,
    output logic [31:0] s_hwdata_o,
    output logic        s_hsel_o,
    output logic [2:0]  s_hburst_o,
    output logic [3:0]  s_hprot_o,
    output logic        s_hmastlock_o,
    input  logic [31:0] s_hrdata_i,
    input  logic        s_hready_i,
    input  logic        s_hresp_i
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;

    logic        pend0_q, pend0_d, pend1_q, pend1_d;
    logic [31:0] hold0_addr_q, hold0_addr_d, hold1_addr_q, hold1_addr_d;
    logic        hold0_write_q, hold0_write_d, hold1_write_q, hold1_write_d;
    logic [2:0]  hold0_size_q, hold0_size_d, hold1_size_q, hold1_size_d;
    owner_e      owner_q, owner_d;
    logic        last_m1_q, last_m1_d;

    logic        m0_rdy_s, m1_rdy_s;
    logic        acc0_s, acc1_s, cand0_s, cand1_s;
    logic        grant_s, win_m1_s;

    // State register with synchronous reset; last=M1 lets M0 win the first tie
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            pend0_q       <= 1'b0;
            pend1_q       <= 1'b0;
            hold0_addr_q  <= 32'd0;
            hold1_addr_q  <= 32'd0;
            hold0_write_q <= 1'b0;
            hold1_write_q <= 1'b0;
            hold0_size_q  <= 3'd0;
            hold1_size_q  <= 3'd0;
            owner_q       <= OWN_NONE;
            last_m1_q     <= 1'b1;
        end else begin
            pend0_q       <= pend0_d;
            pend1_q       <= pend1_d;
            hold0_addr_q  <= hold0_addr_d;
            hold1_addr_q  <= hold1_addr_d;
            hold0_write_q <= hold0_write_d;
            hold1_write_q <= hold1_write_d;
            hold0_size_q  <= hold0_size_d;
            hold1_size_q  <= hold1_size_d;
            owner_q       <= owner_d;
            last_m1_q     <= last_m1_d;
        end
    end

    // Master ready, request acceptance and round-robin winner selection
    always_comb begin
        m0_rdy_s = 1'b1;
        m1_rdy_s = 1'b1;
        if (pend0_q) begin
            m0_rdy_s = 1'b0;
        end else if (owner_q == OWN_M0) begin
            m0_rdy_s = s_hready_i;
        end else begin
            m0_rdy_s = 1'b1;
        end
        if (pend1_q) begin
            m1_rdy_s = 1'b0;
        end else if (owner_q == OWN_M1) begin
            m1_rdy_s = s_hready_i;
        end else begin
            m1_rdy_s = 1'b1;
        end
        acc0_s  = (m0_htrans_i == HTRANS_NONSEQ) && m0_rdy_s;
        acc1_s  = (m1_htrans_i == HTRANS_NONSEQ) && m1_rdy_s;
        cand0_s = pend0_q || acc0_s;
        cand1_s = pend1_q || acc1_s;
        grant_s = s_hready_i && (cand0_s || cand1_s);
        if (cand0_s && cand1_s) begin
            win_m1_s = ~last_m1_q;
        end else begin
            win_m1_s = cand1_s;
        end
    end

    // Slave address phase mux; a pending capture takes precedence over live inputs
    always_comb begin
        s_htrans_o = HTRANS_IDLE;
        s_haddr_o  = 32'd0;
        s_hwrite_o = 1'b0;
        s_hsize_o  = 3'd0;
        if (grant_s && win_m1_s) begin
            s_htrans_o = HTRANS_NONSEQ;
            s_haddr_o  = pend1_q ? hold1_addr_q  : m1_haddr_i;
            s_hwrite_o = pend1_q ? hold1_write_q : m1_hwrite_i;
            s_hsize_o  = pend1_q ? hold1_size_q  : m1_hsize_i;
        end else if (grant_s) begin
            s_htrans_o = HTRANS_NONSEQ;
            s_haddr_o  = pend0_q ? hold0_addr_q  : m0_haddr_i;
            s_hwrite_o = pend0_q ? hold0_write_q : m0_hwrite_i;
            s_hsize_o  = pend0_q ? hold0_size_q  : m0_hsize_i;
        end else begin
            s_htrans_o = HTRANS_IDLE;
            s_haddr_o  = 32'd0;
        end
    end

    // Next-state: pending capture/clear, data-phase owner and last-granted master
    always_comb begin
        pend0_d       = pend0_q;
        pend1_d       = pend1_q;
        hold0_addr_d  = hold0_addr_q;
        hold1_addr_d  = hold1_addr_q;
        hold0_write_d = hold0_write_q;
        hold1_write_d = hold1_write_q;
        hold0_size_d  = hold0_size_q;
        hold1_size_d  = hold1_size_q;
        owner_d       = owner_q;
        last_m1_d     = last_m1_q;
        if (grant_s && !win_m1_s) begin
            pend0_d = 1'b0;
        end else if (acc0_s) begin
            pend0_d       = 1'b1;
            hold0_addr_d  = m0_haddr_i;
            hold0_write_d = m0_hwrite_i;
            hold0_size_d  = m0_hsize_i;
        end else begin
            pend0_d = pend0_q;
        end
        if (grant_s && win_m1_s) begin
            pend1_d = 1'b0;
        end else if (acc1_s) begin
            pend1_d       = 1'b1;
            hold1_addr_d  = m1_haddr_i;
            hold1_write_d = m1_hwrite_i;
            hold1_size_d  = m1_hsize_i;
        end else begin
            pend1_d = pend1_q;
        end
        if (grant_s) begin
            owner_d   = win_m1_s ? OWN_M1 : OWN_M0;
            last_m1_d = win_m1_s;
        end else if (s_hready_i) begin
            owner_d = OWN_NONE;
        end else begin
            owner_d = owner_q;
        end
    end

    // Data-phase routing follows the registered owner
    always_comb begin
        m0_hready_o = m0_rdy_s;
        m1_hready_o = m1_rdy_s;
        m0_hresp_o  = 1'b0;
        m1_hresp_o  = 1'b0;
        s_hwdata_o  = 32'd0;
        case (owner_q)
            OWN_M0: begin
                m0_hresp_o = s_hresp_i;
                s_hwdata_o = m0_hwdata_i;
            end
            OWN_M1: begin
                m1_hresp_o = s_hresp_i;
                s_hwdata_o = m1_hwdata_i;
            end
            default: begin
                s_hwdata_o = 32'd0;
            end
        endcase
    end

    assign m0_hrdata_o   = s_hrdata_i;
    assign m1_hrdata_o   = s_hrdata_i;
    assign s_hsel_o      = 1'b1;
    assign s_hburst_o    = 3'd0;
    assign s_hprot_o     = 4'b0011;
    assign s_hmastlock_o = 1'b0;

endmodule

// File: doc/ahb_arbiter2.md
AHB_ARBITER2 -- requirements
Module: ahb_arbiter2

Interface
- REQ-001 Parameters: none. One clock; reset is synchronous and active-high.
- REQ-002 s_clk_i  input  1  clock; all state updates on rising edge.
- REQ-003 s_reset_i  input  1  synchronous active-high reset.
- REQ-004 m0_haddr_i / m1_haddr_i  input  32  master address.
- REQ-005 m0_hwrite_i / m1_hwrite_i  input  1  write flag.
- REQ-006 m0_hsize_i / m1_hsize_i  input  3  transfer size.
- REQ-007 m0_htrans_i / m1_htrans_i  input  2  transfer type; only NONSEQ (2'd2) is a request, all other values are IDLE.
- REQ-008 m0_hwdata_i / m1_hwdata_i  input  32  write data, data phase.
- REQ-009 m0_hrdata_o / m1_hrdata_o  output  32  read data; both equal s_hrdata_i.
- REQ-010 m0_hready_o / m1_hready_o  output  1  per-master ready.
- REQ-011 m0_hresp_o / m1_hresp_o  output  1  per-master error response.
- REQ-012 s_haddr_o, s_hwrite_o, s_hsize_o, s_htrans_o, s_hwdata_o  output  32/1/3/2/32  shared slave address and data phase.
- REQ-013 s_hsel_o  output  1  constant 1.
- REQ-014 s_hburst_o  output  3  constant 0.
- REQ-015 s_hprot_o  output  4  constant 4'b0011.
- REQ-016 s_hmastlock_o  output  1  constant 0.
- REQ-017 s_hrdata_i, s_hready_i, s_hresp_i  input  32/1/1  slave response.

Function
- REQ-018 State: pend0, pend1 (pending flags); hold0, hold1 (haddr, hwrite, hsize capture registers); dp_owner ∈ {NONE, M0, M1}; last (last-granted master).
- REQ-019 Request acceptance from master i: mi_htrans_i==NONSEQ and mi_hready_o==1 in the same cycle.
- REQ-020 Candidate i: pendi==1 (uses holdi), or an accepted live request (uses live inputs); pendi has precedence over live inputs.
- REQ-021 Grant: issued only when s_hready_i==1.
  - one candidate: that candidate wins.
  - two candidates: the master != last wins (round-robin).
  - last updates on every grant.
- REQ-022 Granted cycle: s_htrans_o=NONSEQ and s_haddr_o/s_hwrite_o/s_hsize_o come from the winning source; next cycle dp_owner=winner.
- REQ-023 No grant:
  - s_htrans_o=IDLE and s_haddr_o = 0.
  - if s_hready_i==1, next cycle dp_owner=NONE; if 0, dp_owner holds.
- REQ-024 An accepted live request that is not granted is captured into holdi and sets pendi at the next edge.
- REQ-025 pendi clears at the edge following its grant.
- REQ-026 pendi and an accepted live request from the same master are never both present: pendi forces mi_hready_o=0.
- REQ-027 mi_hready_o:
  - 0 if pendi==1;
  - else s_hready_i if dp_owner==Mi;
  - else 1.
- REQ-028 mi_hresp_o = s_hresp_i if dp_owner==Mi, else 0.
- REQ-029 s_hwdata_o = hwdata of dp_owner; 0 when dp_owner==NONE.
- REQ-030 Latency:
  - granted live request: 0 added cycles.
  - request losing arbitration: +1 cycle per lost grant slot.
  - the loser wins the next grant slot, so waiting is bounded.
- REQ-031 Slave wait state (s_hready_i==0): no grant; the non-owner master may still be accepted and go pending; the owner sees hready=0.
- REQ-032 Error: s_hresp_i is forwarded only to dp_owner; a pending request of the other master is granted once s_hready_i==1.
- REQ-033 Write followed by read of another master: ordering is grant order; the arbiter performs no forwarding.

Reset
- REQ-034 With s_reset_i=1 at an edge: pend0=pend1=0, dp_owner=NONE, last=M1 (M0 wins first tie).
- REQ-035 After reset: m*_hready_o=1, m*_hresp_o=0, s_htrans_o=IDLE unless a live request is present.
- REQ-036 Reset mid-transfer discards pending and in-flight transfers without completion.

Verification
- REQ-037 After reset, M0 NONSEQ read 0x10 alone, s_hready_i=1 -> s_htrans_o=2, s_haddr_o=0x10 same cycle; next cycle m0_hready_o=1 and m0_hrdata_o=s_hrdata_i.
- REQ-038 M0 and M1 NONSEQ in the same cycle (0x20, 0x40) after reset:
  - M0 granted.
  - M1 pending, m1_hready_o=0 for 1 cycle.
  - s_haddr_o=0x40 the next cycle.
  - m1_hready_o=1 one cycle after that.
- REQ-039 Both masters requesting continuously -> grants alternate M0,M1,M0,M1; no master waits more than 1 slot.
- REQ-040 M1 pending write of 0xA5A5A5A5 to 0x80 while M0 data phase holds s_hready_i=0 for 2 cycles:
  - no grant until s_hready_i=1.
  - then s_haddr_o=0x80.
  - next cycle s_hwdata_o=0xA5A5A5A5.
- REQ-041 s_hresp_i=1 for 2 cycles during an M0 data phase -> m0_hresp_o=1, m1_hresp_o=0 throughout.
- REQ-042 s_reset_i=1 while pend1=1 -> pend1=0, m1_hready_o=1 next cycle; no slave transfer issued for it.
